// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: beat kind codes, base opcodes, the field packer
// used by the instruction encoder, and the immediate range check used when
// IMM_CHECK_EN is defined. Also intended for reuse by the control decoder.
package rv32_pkg;

  typedef enum logic [3:0] {
    KindR      = 4'd0,
    KindIAlu   = 4'd1,
    KindLoad   = 4'd2,
    KindStore  = 4'd3,
    KindBranch = 4'd4,
    KindJal    = 4'd5,
    KindJalr   = 4'd6,
    KindLui    = 4'd7,
    KindAuipc  = 4'd8
  } kind_e;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpIAlu   = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  function automatic logic kind_legal(input logic [3:0] kind);
    return kind <= KindAuipc;
  endfunction

  // True when imm fits the format's immediate field without loss.
  function automatic logic imm_ok(input logic [3:0] kind, input logic [31:0] imm);
    logic ok;
    ok = 1'b1;
    case (kind)
      KindIAlu, KindLoad, KindJalr, KindStore: ok = (imm[31:11] == {21{imm[11]}});
      KindBranch: ok = (imm[31:12] == {20{imm[12]}}) && !imm[0];
      KindJal:    ok = (imm[31:20] == {12{imm[20]}}) && !imm[0];
      KindLui, KindAuipc: ok = (imm[11:0] == 12'h000);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] encode(input logic [3:0] kind, input logic [2:0] f3,
                                         input logic f7b5, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [31:0] imm);
    logic [31:0] inst;
    inst = 32'h0;
    case (kind)
      KindR:      inst = {1'b0, f7b5, 5'b00000, rs2, rs1, f3, rd, OpR};
      KindIAlu:   inst = {imm[11:0], rs1, f3, rd, OpIAlu};
      KindLoad:   inst = {imm[11:0], rs1, f3, rd, OpLoad};
      KindStore:  inst = {imm[11:5], rs2, rs1, f3, imm[4:0], OpStore};
      KindBranch: inst = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OpBranch};
      KindJal:    inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OpJal};
      KindJalr:   inst = {imm[11:0], rs1, 3'b000, rd, OpJalr};
      KindLui:    inst = {imm[31:12], rd, OpLui};
      KindAuipc:  inst = {imm[31:12], rd, OpAuipc};
      default:    inst = 32'h0;
    endcase
    return inst;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy count.
// Ports: clk/rst (sync, active-high), push/wdata write side, pop/rdata read side
// (rdata is the head entry, valid when count != 0), count occupancy 0..DEPTH.
// Pushes when full and pops when empty are ignored. DEPTH must be a power of two.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign push_ok = push && (count_q != CW'(DEPTH));
  assign pop_ok  = pop && (count_q != '0);

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs one field beat per accepted handshake into a
// 32-bit instruction word, buffers it in a 4-entry FIFO and streams words out
// with their byte addresses (BASE_ADDR, +4 per output transfer, mod 2^32).
// Ports: clk, rst (sync, active-high); in_valid/in_ready and in_* fields on the
// input side; out_valid/out_ready, out_inst, out_addr on the output side;
// err sticky illegal-beat flag; count FIFO occupancy 0..4.
// Build option: define IMM_CHECK_EN to drop beats whose immediate does not fit.
module instr_encoder
  import rv32_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_kind,
  input  logic [2:0]  in_funct3,
  input  logic        in_f7b5,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [2:0]  count
);

  typedef enum logic [1:0] {StIdle, StStream, StFull} state_e;

  state_e      state_q;
  logic        err_q;
  logic [31:0] addr_q;
  logic        accept, beat_ok, push, pop;
  logic [2:0]  fifo_count, count_next;
  logic [63:0] head_data;
  logic [31:0] unused_reserved;

  // Handshake signals come from the registered state, which always mirrors
  // the FIFO occupancy, so no full-cycle pass-through can occur.
  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StIdle);

  assign accept = in_valid && in_ready && !rst;
`ifdef IMM_CHECK_EN
  assign beat_ok = kind_legal(in_kind) && imm_ok(in_kind, in_imm);
`else
  assign beat_ok = kind_legal(in_kind);
`endif
  assign push = accept && beat_ok;
  assign pop  = out_valid && out_ready;

  assign count_next = fifo_count + {2'b00, push} - {2'b00, pop};

  sync_fifo #(
    .WIDTH (64),
    .DEPTH (4)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({encode(in_kind, in_funct3, in_f7b5, in_rd, in_rs1, in_rs2, in_imm), 32'h0}),
    .pop   (pop),
    .rdata (head_data),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
      addr_q  <= BASE_ADDR;
    end else begin
      if (accept && !beat_ok) err_q <= 1'b1;
      if (pop) addr_q <= addr_q + 32'd4;
      case (count_next)
        3'd0:    state_q <= StIdle;
        3'd4:    state_q <= StFull;
        default: state_q <= StStream;
      endcase
    end
  end

  // Empty FIFO memory is uninitialised; present zero rather than stale data.
  assign out_inst        = out_valid ? head_data[63:32] : 32'h0;
  assign unused_reserved = head_data[31:0];
  assign out_addr        = addr_q;
  assign err             = err_q;
  assign count           = fifo_count;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'hFFFF_FFF0;

  typedef struct {
    logic [3:0]  kind;
    logic [2:0]  f3;
    logic        f7b5;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_f7b5, out_valid, out_ready, err;
  logic [3:0]  in_kind;
  logic [2:0]  in_funct3, count;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, out_inst, out_addr;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_addr;
  vec_t        vecs[11];
  vec_t        v;

  always #5 clk = ~clk;

  instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .in_funct3 (in_funct3),
    .in_f7b5   (in_f7b5),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_addr  (out_addr),
    .err       (err),
    .count     (count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t b);
    in_valid  = 1'b1;
    in_kind   = b.kind;
    in_funct3 = b.f3;
    in_f7b5   = b.f7b5;
    in_rd     = b.rd;
    in_rs1    = b.rs1;
    in_rs2    = b.rs2;
    in_imm    = b.imm;
  endtask

  function automatic vec_t lui(input logic [4:0] rd);
    vec_t b;
    b = '{4'd7, 3'd0, 1'b0, rd, 5'd0, 5'd0, 32'h0, {20'h0, rd, 7'h37}};
    return b;
  endfunction

  initial begin
    vecs[0]  = '{4'd0, 3'd0, 1'b0, 5'd3,  5'd1, 5'd2, 32'h0000_0000, 32'h002081B3}; // add
    vecs[1]  = '{4'd0, 3'd0, 1'b1, 5'd3,  5'd1, 5'd2, 32'h0000_0000, 32'h402081B3}; // sub
    vecs[2]  = '{4'd5, 3'd7, 1'b0, 5'd1,  5'd5, 5'd0, 32'h0000_0008, 32'h008000EF}; // jal
    vecs[3]  = '{4'd7, 3'd0, 1'b0, 5'd5,  5'd0, 5'd0, 32'h1234_5000, 32'h123452B7}; // lui
    vecs[4]  = '{4'd1, 3'd0, 1'b0, 5'd1,  5'd2, 5'd0, 32'hFFFF_FFFF, 32'hFFF10093}; // addi -1
    vecs[5]  = '{4'd2, 3'd2, 1'b0, 5'd5,  5'd6, 5'd0, 32'h0000_0008, 32'h00832283}; // lw
    vecs[6]  = '{4'd3, 3'd2, 1'b0, 5'd0,  5'd8, 5'd7, 32'h0000_000C, 32'h00742623}; // sw
    vecs[7]  = '{4'd4, 3'd0, 1'b0, 5'd0,  5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE208EE3}; // beq -4
    vecs[8]  = '{4'd6, 3'd5, 1'b0, 5'd1,  5'd5, 5'd0, 32'h0000_0010, 32'h010280E7}; // jalr
    vecs[9]  = '{4'd8, 3'd0, 1'b0, 5'd10, 5'd0, 5'd0, 32'hABCD_E000, 32'hABCDE517}; // auipc
    vecs[10] = '{4'd0, 3'd5, 1'b1, 5'd4,  5'd5, 5'd6, 32'h0000_0000, 32'h4062D233}; // sra

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_kind = '0; in_funct3 = '0; in_f7b5 = 1'b0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    step(); step();
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_count", {29'h0, count}, 32'h0);
    check("rst_out_inst", out_inst, 32'h0);
    check("rst_out_addr", out_addr, BASE);
    rst = 1'b0;
    exp_addr = BASE;
    out_ready = 1'b1;

    // Single beats, latency 1; addresses wrap past 2^32 during the table.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i]);
      check($sformatf("vec%0d_in_ready", i), {31'h0, in_ready}, 32'h1);
      step();
      in_valid = 1'b0;
      check($sformatf("vec%0d_out_valid", i), {31'h0, out_valid}, 32'h1);
      check($sformatf("vec%0d_inst", i), out_inst, vecs[i].exp);
      check($sformatf("vec%0d_addr", i), out_addr, exp_addr);
      step();
      exp_addr = exp_addr + 32'd4;
      check($sformatf("vec%0d_drained", i), {31'h0, out_valid}, 32'h0);
    end

    // Backpressure: fill four entries, fifth stalls until a pop frees a slot.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(lui(5'(i + 1)));
      check($sformatf("fill%0d_in_ready", i), {31'h0, in_ready}, 32'h1);
      step();
    end
    drive(lui(5'd5));
    check("full_in_ready", {31'h0, in_ready}, 32'h0);
    check("full_count", {29'h0, count}, 32'h4);
    step(); step();
    check("full_hold_count", {29'h0, count}, 32'h4);
    check("full_hold_inst", out_inst, lui(5'd1).exp);
    check("full_hold_addr", out_addr, exp_addr);
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      v = lui(5'(j + 1));
      check($sformatf("drain%0d_inst", j), out_inst, v.exp);
      check($sformatf("drain%0d_addr", j), out_addr, exp_addr);
      if (j == 0) check("drain0_in_ready", {31'h0, in_ready}, 32'h0);
      if (j == 1) begin
        check("drain1_in_ready", {31'h0, in_ready}, 32'h1);
        check("drain1_count", {29'h0, count}, 32'h3);
      end
      step();
      exp_addr = exp_addr + 32'd4;
      if (j == 1) begin
        in_valid = 1'b0;
        check("pushpop_count", {29'h0, count}, 32'h3);
      end
    end
    check("drain_empty", {31'h0, out_valid}, 32'h0);

    // Illegal kind: consumed, nothing emitted, sticky err.
    v = '{4'd9, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'h0, 32'h0};
    drive(v);
    check("illegal_in_ready", {31'h0, in_ready}, 32'h1);
    step();
    in_valid = 1'b0;
    check("illegal_no_out", {31'h0, out_valid}, 32'h0);
    check("illegal_err", {31'h0, err}, 32'h1);
    step(); step();
    check("illegal_err_sticky", {31'h0, err}, 32'h1);

    // Out-of-range I immediate.
    v = '{4'd1, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0000_0800, 32'h80000013};
    drive(v);
    step();
    in_valid = 1'b0;
`ifdef IMM_CHECK_EN
    check("immchk_dropped", {31'h0, out_valid}, 32'h0);
    check("immchk_err", {31'h0, err}, 32'h1);
    step();
`else
    check("imm800_valid", {31'h0, out_valid}, 32'h1);
    check("imm800_inst", out_inst, v.exp);
    check("imm800_addr", out_addr, exp_addr);
    step();
    exp_addr = exp_addr + 32'd4;
`endif

    // Reset with three buffered words and a beat on offer.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(lui(5'(i + 20)));
      step();
    end
    check("pre_rst_count", {29'h0, count}, 32'h3);
    check("pre_rst_addr", out_addr, exp_addr);
    drive(lui(5'd30));
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    check("midrst_count", {29'h0, count}, 32'h0);
    check("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    check("midrst_err", {31'h0, err}, 32'h0);
    check("midrst_in_ready", {31'h0, in_ready}, 32'h1);
    step();
    check("midrst_no_accept", {29'h0, count}, 32'h0);
    out_ready = 1'b1;
    drive(vecs[0]);
    step();
    in_valid = 1'b0;
    check("post_rst_inst", out_inst, vecs[0].exp);
    check("post_rst_addr", out_addr, BASE);
    step();
    check("post_rst_drained", {29'h0, count}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
